// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int unsigned MIN_MOD = 3;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: shifts out the top N bits of a word MSB-first,
// one bit per clock, each qualified by ser_data_val_o.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_I_W = 16,
  parameter int unsigned MOD_W    = $clog2(DATA_I_W)
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [DATA_I_W-1:0] data_i,
  input  logic [MOD_W-1:0]    data_mod_i,
  input  logic                data_val_i,
  output logic                ser_data_o,
  output logic                ser_data_val_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W = MOD_W + 1;

  ser_state_t          state_q, state_d;
  logic [DATA_I_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    n_bits;
  logic                accept;
  logic                ser_d, val_d, busy_d;

  // The first bit is loaded straight from data_i so it appears the cycle after
  // acceptance; cnt_q then holds the number of bits still to follow.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    val_d   = 1'b0;
    busy_d  = 1'b0;

    accept = data_val_i && ((data_mod_i == '0) || (data_mod_i >= MOD_W'(MIN_MOD)));
    n_bits = (data_mod_i == '0) ? CNT_W'(DATA_I_W) : {1'b0, data_mod_i};

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          ser_d   = data_i[DATA_I_W-1];
          shreg_d = {data_i[DATA_I_W-2:0], 1'b0};
          cnt_d   = n_bits - CNT_W'(1);
          val_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          shreg_d = '0;
        end else begin
          ser_d   = shreg_q[DATA_I_W-1];
          shreg_d = {shreg_q[DATA_I_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
          val_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      ser_data_o     <= ser_d;
      ser_data_val_o <= val_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer; inputs change and outputs are
// sampled on the falling clock edge.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  serializer #(.DATA_I_W(16)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    srst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    vectors += 3;
    if (ser_data_o !== 1'b0) begin miscompares++; $display("FAIL reset_ser got %b exp 0", ser_data_o); end
    if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL reset_val got %b exp 0", ser_data_val_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    srst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_full_word();
    logic [15:0] exp_bits = 16'b1010_0101_1100_0011;
    data_i = 16'hA5C3; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0; data_i = '0;
    for (int i = 15; i >= 0; i--) begin
      vectors += 3;
      if (ser_data_o !== exp_bits[i]) begin miscompares++; $display("FAIL full_bit%0d got %b exp %b", 15-i, ser_data_o, exp_bits[i]); end
      if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL full_val%0d got %b exp 1", 15-i, ser_data_val_o); end
      if (busy_o !== 1'b1) begin miscompares++; $display("FAIL full_busy%0d got %b exp 1", 15-i, busy_o); end
      @(negedge clk_i);
    end
    vectors += 3;
    if (ser_data_o !== 1'b0) begin miscompares++; $display("FAIL full_end_ser got %b exp 0", ser_data_o); end
    if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL full_end_val got %b exp 0", ser_data_val_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL full_end_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_partial();
    logic [4:0] exp_bits = 5'b11110;
    data_i = 16'hF000; data_mod_i = 4'd5; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0; data_i = '0; data_mod_i = '0;
    for (int i = 4; i >= 0; i--) begin
      vectors += 3;
      if (ser_data_o !== exp_bits[i]) begin miscompares++; $display("FAIL part_bit%0d got %b exp %b", 4-i, ser_data_o, exp_bits[i]); end
      if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL part_val%0d got %b exp 1", 4-i, ser_data_val_o); end
      if (busy_o !== 1'b1) begin miscompares++; $display("FAIL part_busy%0d got %b exp 1", 4-i, busy_o); end
      @(negedge clk_i);
    end
    for (int k = 0; k < 2; k++) begin
      vectors += 3;
      if (ser_data_o !== 1'b0) begin miscompares++; $display("FAIL part_end_ser got %b exp 0", ser_data_o); end
      if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL part_end_val got %b exp 0", ser_data_val_o); end
      if (busy_o !== 1'b0) begin miscompares++; $display("FAIL part_end_busy got %b exp 0", busy_o); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_rejected_mod();
    logic [2:0] exp_bits = 3'b010;
    for (int m = 1; m <= 2; m++) begin
      data_i = 16'hFFFF; data_mod_i = 4'(m); data_val_i = 1'b1;
      @(negedge clk_i);
      data_val_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
        vectors += 3;
        if (ser_data_o !== 1'b0) begin miscompares++; $display("FAIL rej_mod%0d_ser got %b exp 0", m, ser_data_o); end
        if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL rej_mod%0d_val got %b exp 0", m, ser_data_val_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rej_mod%0d_busy got %b exp 0", m, busy_o); end
        @(negedge clk_i);
      end
    end
    data_i = 16'h4000; data_mod_i = 4'd3; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0; data_i = '0; data_mod_i = '0;
    for (int i = 2; i >= 0; i--) begin
      vectors += 2;
      if (ser_data_o !== exp_bits[i]) begin miscompares++; $display("FAIL mod3_bit%0d got %b exp %b", 2-i, ser_data_o, exp_bits[i]); end
      if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL mod3_val%0d got %b exp 1", 2-i, ser_data_val_o); end
      @(negedge clk_i);
    end
    vectors += 2;
    if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL mod3_end_val got %b exp 0", ser_data_val_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL mod3_end_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_ignore_busy();
    data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vectors += 2;
      if (ser_data_o !== 1'b1) begin miscompares++; $display("FAIL busy_bit%0d got %b exp 1", i, ser_data_o); end
      if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL busy_val%0d got %b exp 1", i, ser_data_val_o); end
      // Pulse a competing request during the eighth bit.
      if (i == 7) begin data_i = 16'h0000; data_mod_i = 4'd0; data_val_i = 1'b1; end
      else data_val_i = 1'b0;
      @(negedge clk_i);
    end
    for (int k = 0; k < 4; k++) begin
      vectors += 2;
      if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL busy_nosecond_val got %b exp 0", ser_data_val_o); end
      if (busy_o !== 1'b0) begin miscompares++; $display("FAIL busy_nosecond_busy got %b exp 0", busy_o); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_bits = 4'b1001;
    data_i = 16'h9000; data_mod_i = 4'd4; data_val_i = 1'b1;
    @(negedge clk_i);
    for (int b = 0; b < 3; b++) begin
      for (int i = 3; i >= 0; i--) begin
        vectors += 3;
        if (ser_data_o !== exp_bits[i]) begin miscompares++; $display("FAIL b2b%0d_bit%0d got %b exp %b", b, 3-i, ser_data_o, exp_bits[i]); end
        if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL b2b%0d_val%0d got %b exp 1", b, 3-i, ser_data_val_o); end
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL b2b%0d_busy%0d got %b exp 1", b, 3-i, busy_o); end
        @(negedge clk_i);
      end
      vectors += 2;
      if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_gap_val got %b exp 0", b, ser_data_val_o); end
      if (busy_o !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_gap_busy got %b exp 0", b, busy_o); end
      if (b == 2) data_val_i = 1'b0;
      @(negedge clk_i);
    end
    vectors += 1;
    if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL b2b_stop_val got %b exp 0", ser_data_val_o); end
    data_i = '0; data_mod_i = '0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] exp_bits = 16'h8001;
    data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    repeat (5) @(negedge clk_i);
    vectors += 1;
    if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_bit6_val got %b exp 1", ser_data_val_o); end
    srst_i = 1'b0;
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) srst_i = 1'b1;
      vectors += 3;
      if (ser_data_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_ser%0d got %b exp 0", k, ser_data_o); end
      if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_val%0d got %b exp 0", k, ser_data_val_o); end
      if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy%0d got %b exp 0", k, busy_o); end
      @(negedge clk_i);
    end
    data_i = 16'h8001; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0; data_i = '0;
    for (int i = 15; i >= 0; i--) begin
      vectors += 2;
      if (ser_data_o !== exp_bits[i]) begin miscompares++; $display("FAIL post_rst_bit%0d got %b exp %b", 15-i, ser_data_o, exp_bits[i]); end
      if (ser_data_val_o !== 1'b1) begin miscompares++; $display("FAIL post_rst_val%0d got %b exp 1", 15-i, ser_data_val_o); end
      @(negedge clk_i);
    end
    vectors += 2;
    if (ser_data_val_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_end_val got %b exp 0", ser_data_val_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_end_busy got %b exp 0", busy_o); end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_full_word();
    test_partial();
    test_rejected_mod();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial converter, the transmit counterpart of the team's deserializer. Accepts one parallel word with a bit-count modifier and shifts out the selected number of bits MSB-first, one bit per clock, each bit qualified by a valid strobe. Sits between a word-wide producer and any single-bit serial sink, including our deserializer for loopback.

## Interface
- `DATA_I_W`, default 16: parallel word width; must be ≥ 4 and a power of two.
- `MOD_W`, default `$clog2(DATA_I_W)`: width of the bit-count modifier (derived; do not override).
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `srst_i`  in  1  reset; synchronous, active-low (asserted when 0).
- `data_i`  in  `DATA_I_W`  parallel word; bit `DATA_I_W-1` is sent first.
- `data_mod_i`  in  `MOD_W`  number of bits to send, taken from the top of `data_i`; 0 means all `DATA_I_W` bits.
- `data_val_i`  in  1  request strobe; sampled only while `busy_o` is 0.
- `ser_data_o`  out  1  current serial bit.
- `ser_data_val_o`  out  1  `ser_data_o` is valid this cycle.
- `busy_o`  out  1  transfer in progress; new requests are ignored.

## Operation
- States: `IDLE`, `SHIFT`.
- `IDLE`: if `data_val_i`=1 and `data_mod_i` ∉ {1, 2}, capture `data_i` into the shift register, load the bit count N (N = `DATA_I_W` when `data_mod_i`=0, else `data_mod_i`), and go to `SHIFT`.
- `data_mod_i` = 1 or 2: the request is dropped. State stays `IDLE`; there is no output activity and no error flag.
- `SHIFT`: drive the MSB of the shift register, then shift left by one and decrement the remaining count. After the N-th bit, return to `IDLE`.
- `data_val_i`, `data_i` and `data_mod_i` are don't-care while `busy_o`=1. They are not queued and do not corrupt the transfer in flight.
- Counter width is `MOD_W+1`, so a count of `DATA_I_W` is representable. The counter never wraps.
- Bits of `data_i` below the selected N are never emitted.
- `ser_data_o` = 0 whenever `ser_data_val_o` = 0.

## Timing
- Reset (`srst_i`=0 at a clock edge):
  - all outputs go to 0; state becomes `IDLE`; shift register and counter are cleared.
  - This takes effect immediately and also aborts a transfer mid-word. No partial bits appear after reset.
- Latency: request accepted at edge t → first bit is valid in cycle t+1.
- `ser_data_val_o` and `busy_o` are both high for exactly N consecutive cycles (t+1 … t+N) and are low otherwise. `busy_o` is registered, not combinational.
- A request presented at the edge after the last bit (cycle t+N+1, `busy_o`=0) is accepted. Its first bit appears at t+N+2.
- Minimum inter-word gap is therefore one idle cycle.
- A request held high continuously during a transfer is re-sampled at the first cycle with `busy_o`=0 and starts a new transfer then.
- All outputs are driven from flops; there is no input-to-output combinational path.

## Structure
- Package `serializer_pkg`:
  - `typedef enum logic {IDLE, SHIFT} ser_state_t`
  - localparam `MIN_MOD = 3` (smallest accepted non-zero modifier)
- Single flat module; no sub-module is warranted. The datapath is a shift register plus a down-counter next to a two-state FSM.

## Test plan
- Reset then full word: `data_i`=16'hA5C3, `data_mod_i`=0, one-cycle `data_val_i` → 16 valid cycles, bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; `busy_o` high for the same 16 cycles.
- Partial word: `data_i`=16'hF000, `data_mod_i`=5 → 5 valid cycles, bits 1,1,1,1,0; then `ser_data_val_o` and `busy_o` return to 0.
- Rejected modifiers: `data_mod_i`=1, then 2, each with `data_val_i` → no `busy_o`, no `ser_data_val_o`. A following request with `data_mod_i`=3 and `data_i`=16'h4000 → bits 0,1,0.
- Ignore while busy: start 16'hFFFF with mod 0; pulse `data_val_i` with 16'h0000 at bit 8 → all 16 output bits are 1 and no second transfer occurs.
- Back-to-back: hold `data_val_i`=1 with mod 4, `data_i`=16'h9000 → bursts 1,0,0,1 repeat with exactly one idle cycle between bursts.
- Reset mid-word: assert `srst_i`=0 at bit 6 of a 16-bit transfer → outputs 0 from the next cycle. After release, the next request serializes cleanly from its MSB.
